stage_tl: RTL and testbench

//  - Translation stage between EX and the data-cache (DC) stage.
//  - Registers the EX->TL bundle and selects ALU vs multiplier result.
//  - Translates memory addresses through a fully associative DTLB and installs DTLB entries on tlbwrite.
//  - Honours downstream stall. Latency 1 cycle to the DC interface.

---
 rtl/stage_tl_pkg.sv | 36 +++
 rtl/stage_tl_dtlb.sv | 69 ++++++
 rtl/stage_tl.sv | 136 +++++++++++++
 tb/tb_stage_tl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_tl_pkg.sv
// Shared types and constants for the TL (translation) pipeline stage and its DTLB.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package stage_tl_pkg;

   localparam int WORD_W        = 32;
   localparam int PAGE_OFFSET_W = 12;
   localparam int VPN_W         = 20;
   localparam int PPN_W         = 8;
   localparam int PADDR_W       = PPN_W + PAGE_OFFSET_W;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [WORD_W-1:0]  vptr_t;
   typedef logic [PADDR_W-1:0] pptr_t;
   typedef logic [4:0]         regid_t;
   typedef logic [1:0]         threadid_t;

   typedef enum logic [1:0] {
      TLBW_OFF  = 2'd0,
      TLBW_ITLB = 2'd1,
      TLBW_DTLB = 2'd2
   } tlbwrite_t;

   typedef struct packed {
      logic             valid;
      logic [VPN_W-1:0] vpn;
      logic [PPN_W-1:0] ppn;
   } tlb_entry_t;

   // Physical address is the page frame number glued onto the untranslated page offset.
   function automatic pptr_t make_paddr(input logic [PPN_W-1:0] ppn,
                                        input logic [PAGE_OFFSET_W-1:0] offset);
      return {ppn, offset};
   endfunction

endpackage

// File: rtl/stage_tl_dtlb.sv
// Fully associative data TLB: combinational lookup, round-robin install on miss-write.
// Latency: lookup is combinational; an install becomes visible on the next cycle.
// Backpressure: none internally; the caller gates i_wr_en with its own stall.
module stage_tl_dtlb
   import stage_tl_pkg::*;
#(
   parameter int ENTRIES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [VPN_W-1:0] i_lk_vpn,
   input  logic             i_wr_en,
   input  logic [VPN_W-1:0] i_wr_vpn,
   input  logic [PPN_W-1:0] i_wr_ppn,
   output logic             o_hit,
   output logic [PPN_W-1:0] o_ppn
);

   localparam int RP_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   tlb_entry_t      r_entries [ENTRIES];
   logic [RP_W-1:0] r_rp;

   logic            w_wr_match;
   logic [RP_W-1:0] w_wr_idx;
   logic [RP_W-1:0] w_wr_slot;

   // Lookup: installs never duplicate a VPN, so at most one entry matches and OR-ing is safe.
   always_comb begin
      o_hit = 1'b0;
      o_ppn = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (r_entries[i].valid && (r_entries[i].vpn == i_lk_vpn)) begin
            o_hit = 1'b1;
            o_ppn = o_ppn | r_entries[i].ppn;
         end
      end
   end

   // Write-side search: an already-present VPN is overwritten in place instead of taking the rp slot.
   always_comb begin
      w_wr_match = 1'b0;
      w_wr_idx   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (r_entries[i].valid && (r_entries[i].vpn == i_wr_vpn)) begin
            w_wr_match = 1'b1;
            w_wr_idx   = RP_W'(i);
         end
      end
   end

   assign w_wr_slot = w_wr_match ? w_wr_idx : r_rp;

   // Entry array and replacement pointer; rp advances (wrapping) only when a fresh slot is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_entries[i] <= '0;
         end
         r_rp <= '0;
      end else if (i_wr_en) begin
         r_entries[w_wr_slot] <= '{valid: 1'b1, vpn: i_wr_vpn, ppn: i_wr_ppn};
         if (!w_wr_match) begin
            r_rp <= r_rp + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stage_tl.sv
// EX->DC translation stage: registers the EX bundle, selects ALU/MUL result, translates via DTLB.
// Latency: 1 cycle from tl_* inputs to dc_* outputs.
// Backpressure: dc_stall holds every dc_* register and blocks DTLB installs; echoed on tl_stall.
module stage_tl
   import stage_tl_pkg::*;
#(
   parameter int DTLB_ENTRIES = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  threadid_t tl_thread,
   input  logic      tl_isvalid,
   input  logic      tl_itlb_miss,
   input  vptr_t     tl_pc,
   input  word_t     tl_data,
   input  word_t     tl_mul,
   input  word_t     tl_r2,
   input  regid_t    tl_dst,
   input  logic      tl_isequal,
   input  logic      tl_flag_mem,
   input  logic      tl_flag_store,
   input  logic      tl_flag_isbyte,
   input  logic      tl_flag_mul,
   input  logic      tl_flag_reg,
   input  logic      tl_flag_jump,
   input  logic      tl_flag_branch,
   input  logic      tl_flag_iret,
   input  tlbwrite_t tl_flag_tlbwrite,
   input  logic      tl_supervisor,
   input  logic      tl_kill,
   input  logic      dc_stall,
   output logic      tl_stall,
   output threadid_t dc_thread,
   output logic      dc_isvalid,
   output logic      dc_itlb_miss,
   output vptr_t     dc_pc,
   output word_t     dc_r2,
   output regid_t    dc_dst,
   output logic      dc_isequal,
   output logic      dc_flag_mem,
   output logic      dc_flag_store,
   output logic      dc_flag_isbyte,
   output logic      dc_flag_reg,
   output logic      dc_flag_jump,
   output logic      dc_flag_branch,
   output logic      dc_flag_iret,
   output word_t     dc_data,
   output pptr_t     dc_paddr,
   output logic      dc_dtlb_miss
);

   logic             w_wr_en;
   logic             w_hit;
   logic [PPN_W-1:0] w_ppn;
   pptr_t            w_paddr;
   logic             w_miss;
   word_t            w_data;

   assign tl_stall = dc_stall;

   // Only a live, unstalled supervisor instruction may install into the DTLB.
   assign w_wr_en = tl_isvalid & ~tl_kill & ~dc_stall & tl_supervisor
                  & (tl_flag_tlbwrite == TLBW_DTLB);

   assign w_data = tl_flag_mul ? tl_mul : tl_data;

   stage_tl_dtlb #(
      .ENTRIES (DTLB_ENTRIES)
   ) u_dtlb (
      .clk      (clk),
      .rst      (rst),
      .i_lk_vpn (tl_data[WORD_W-1:PAGE_OFFSET_W]),
      .i_wr_en  (w_wr_en),
      .i_wr_vpn (tl_data[WORD_W-1:PAGE_OFFSET_W]),
      .i_wr_ppn (tl_r2[PADDR_W-1:PAGE_OFFSET_W]),
      .o_hit    (w_hit),
      .o_ppn    (w_ppn)
   );

   // Address selection: supervisor bypasses translation; user misses report zero and flag the miss.
   always_comb begin
      w_paddr = '0;
      w_miss  = 1'b0;
      if (tl_isvalid && tl_flag_mem) begin
         if (tl_supervisor) begin
            w_paddr = tl_data[PADDR_W-1:0];
         end else if (w_hit) begin
            w_paddr = make_paddr(w_ppn, tl_data[PAGE_OFFSET_W-1:0]);
         end else begin
            w_miss = 1'b1;
         end
      end
   end

   // TL->DC pipeline register; a kill only takes effect on the cycle the instruction actually advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         dc_thread      <= '0;
         dc_isvalid     <= 1'b0;
         dc_itlb_miss   <= 1'b0;
         dc_pc          <= '0;
         dc_r2          <= '0;
         dc_dst         <= '0;
         dc_isequal     <= 1'b0;
         dc_flag_mem    <= 1'b0;
         dc_flag_store  <= 1'b0;
         dc_flag_isbyte <= 1'b0;
         dc_flag_reg    <= 1'b0;
         dc_flag_jump   <= 1'b0;
         dc_flag_branch <= 1'b0;
         dc_flag_iret   <= 1'b0;
         dc_data        <= '0;
         dc_paddr       <= '0;
         dc_dtlb_miss   <= 1'b0;
      end else if (!dc_stall) begin
         dc_thread      <= tl_thread;
         dc_isvalid     <= tl_isvalid & ~tl_kill;
         dc_itlb_miss   <= tl_itlb_miss;
         dc_pc          <= tl_pc;
         dc_r2          <= tl_r2;
         dc_dst         <= tl_dst;
         dc_isequal     <= tl_isequal;
         dc_flag_mem    <= tl_flag_mem;
         dc_flag_store  <= tl_flag_store;
         dc_flag_isbyte <= tl_flag_isbyte;
         dc_flag_reg    <= tl_flag_reg;
         dc_flag_jump   <= tl_flag_jump;
         dc_flag_branch <= tl_flag_branch;
         dc_flag_iret   <= tl_flag_iret;
         dc_data        <= w_data;
         dc_paddr       <= w_paddr;
         dc_dtlb_miss   <= w_miss;
      end
   end

endmodule

// File: tb/tb_stage_tl.sv
// Directed bench for stage_tl: reset, DTLB fill/hit, wrap/replacement, stall, kill/bypass, result mux.
// Latency: expects results one clock after inputs are driven.
// Backpressure: exercises dc_stall holding outputs and DTLB writes.
module tb_stage_tl;
   import stage_tl_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   threadid_t tl_thread;
   logic      tl_isvalid, tl_itlb_miss;
   vptr_t     tl_pc;
   word_t     tl_data, tl_mul, tl_r2;
   regid_t    tl_dst;
   logic      tl_isequal;
   logic      tl_flag_mem, tl_flag_store, tl_flag_isbyte, tl_flag_mul;
   logic      tl_flag_reg, tl_flag_jump, tl_flag_branch, tl_flag_iret;
   tlbwrite_t tl_flag_tlbwrite;
   logic      tl_supervisor, tl_kill, dc_stall, tl_stall;
   threadid_t dc_thread;
   logic      dc_isvalid, dc_itlb_miss;
   vptr_t     dc_pc;
   word_t     dc_r2;
   regid_t    dc_dst;
   logic      dc_isequal;
   logic      dc_flag_mem, dc_flag_store, dc_flag_isbyte, dc_flag_reg;
   logic      dc_flag_jump, dc_flag_branch, dc_flag_iret;
   word_t     dc_data;
   pptr_t     dc_paddr;
   logic      dc_dtlb_miss;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   stage_tl #(.DTLB_ENTRIES(4)) dut (
      .clk(clk), .rst(rst),
      .tl_thread(tl_thread), .tl_isvalid(tl_isvalid), .tl_itlb_miss(tl_itlb_miss),
      .tl_pc(tl_pc), .tl_data(tl_data), .tl_mul(tl_mul), .tl_r2(tl_r2),
      .tl_dst(tl_dst), .tl_isequal(tl_isequal),
      .tl_flag_mem(tl_flag_mem), .tl_flag_store(tl_flag_store), .tl_flag_isbyte(tl_flag_isbyte),
      .tl_flag_mul(tl_flag_mul), .tl_flag_reg(tl_flag_reg), .tl_flag_jump(tl_flag_jump),
      .tl_flag_branch(tl_flag_branch), .tl_flag_iret(tl_flag_iret),
      .tl_flag_tlbwrite(tl_flag_tlbwrite), .tl_supervisor(tl_supervisor),
      .tl_kill(tl_kill), .dc_stall(dc_stall), .tl_stall(tl_stall),
      .dc_thread(dc_thread), .dc_isvalid(dc_isvalid), .dc_itlb_miss(dc_itlb_miss),
      .dc_pc(dc_pc), .dc_r2(dc_r2), .dc_dst(dc_dst), .dc_isequal(dc_isequal),
      .dc_flag_mem(dc_flag_mem), .dc_flag_store(dc_flag_store), .dc_flag_isbyte(dc_flag_isbyte),
      .dc_flag_reg(dc_flag_reg), .dc_flag_jump(dc_flag_jump), .dc_flag_branch(dc_flag_branch),
      .dc_flag_iret(dc_flag_iret), .dc_data(dc_data), .dc_paddr(dc_paddr),
      .dc_dtlb_miss(dc_dtlb_miss)
   );

   task automatic set_idle();
      tl_thread = '0; tl_isvalid = 1'b0; tl_itlb_miss = 1'b0; tl_pc = '0;
      tl_data = '0; tl_mul = '0; tl_r2 = '0; tl_dst = '0; tl_isequal = 1'b0;
      tl_flag_mem = 1'b0; tl_flag_store = 1'b0; tl_flag_isbyte = 1'b0; tl_flag_mul = 1'b0;
      tl_flag_reg = 1'b0; tl_flag_jump = 1'b0; tl_flag_branch = 1'b0; tl_flag_iret = 1'b0;
      tl_flag_tlbwrite = TLBW_OFF; tl_supervisor = 1'b0; tl_kill = 1'b0; dc_stall = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_tlbw(input logic [19:0] vpn, input logic [7:0] ppn);
      set_idle();
      tl_isvalid = 1'b1; tl_supervisor = 1'b1; tl_flag_tlbwrite = TLBW_DTLB;
      tl_data = {vpn, 12'h000}; tl_r2 = {12'h000, ppn, 12'h000};
   endtask

   task automatic drive_load(input logic [31:0] addr, input logic sup);
      set_idle();
      tl_isvalid = 1'b1; tl_flag_mem = 1'b1; tl_flag_reg = 1'b1; tl_dst = 5'd3;
      tl_data = addr; tl_supervisor = sup;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (dc_isvalid !== 1'b0) $display("FAIL reset_isvalid: got %b want 0", dc_isvalid); else n_pass++;
      drive_tlbw(20'h00003, 8'h33); step();
      drive_load(32'h0000_3000, 1'b0); tl_pc = 32'h44; step();
      n_checks++; if (dc_paddr !== 20'h33000) $display("FAIL pre_reset_hit: got %h want 33000", dc_paddr); else n_pass++;
      // reset mid-stream with a tlbwrite presented: the write must not survive
      drive_tlbw(20'h00003, 8'h33); tl_pc = 32'h48; rst = 1'b1; step(); step();
      n_checks++; if (dc_isvalid !== 1'b0) $display("FAIL rst_isvalid: got %b want 0", dc_isvalid); else n_pass++;
      n_checks++; if (dc_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", dc_pc); else n_pass++;
      n_checks++; if (dc_data !== 32'h0) $display("FAIL rst_data: got %h want 0", dc_data); else n_pass++;
      n_checks++; if (dc_r2 !== 32'h0) $display("FAIL rst_r2: got %h want 0", dc_r2); else n_pass++;
      n_checks++; if (dc_flag_mem !== 1'b0 || dc_dst !== 5'd0) $display("FAIL rst_flags: got mem=%b dst=%h want 0", dc_flag_mem, dc_dst); else n_pass++;
      rst = 1'b0;
      drive_load(32'h0000_3000, 1'b0); step();
      n_checks++; if (dc_dtlb_miss !== 1'b1) $display("FAIL rst_lookup_miss: got %b want 1", dc_dtlb_miss); else n_pass++;
      n_checks++; if (dc_paddr !== 20'h0) $display("FAIL rst_lookup_paddr: got %h want 0", dc_paddr); else n_pass++;
      n_checks++; if (dc_isvalid !== 1'b1) $display("FAIL miss_isvalid: got %b want 1", dc_isvalid); else n_pass++;
   endtask

   task automatic test_fill_hit();
      do_reset();
      drive_tlbw(20'h00005, 8'h0A); tl_r2 = 32'h0000_A000; step();
      drive_load(32'h0000_5ABC, 1'b0); step();
      n_checks++; if (dc_paddr !== 20'h0AABC) $display("FAIL fill_paddr: got %h want 0aabc", dc_paddr); else n_pass++;
      n_checks++; if (dc_dtlb_miss !== 1'b0) $display("FAIL fill_miss: got %b want 0", dc_dtlb_miss); else n_pass++;
      n_checks++; if (dc_data !== 32'h0000_5ABC) $display("FAIL fill_data: got %h want 00005abc", dc_data); else n_pass++;
      drive_load(32'h0000_6000, 1'b0); step();
      n_checks++; if (dc_dtlb_miss !== 1'b1 || dc_paddr !== 20'h0) $display("FAIL unmapped: got miss=%b paddr=%h want 1/0", dc_dtlb_miss, dc_paddr); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [19:0] exp;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive_tlbw(20'(20'h10 + k), 8'(8'h80 + k)); step();
      end
      drive_load({20'h00010, 12'h123}, 1'b0); step();
      n_checks++; if (dc_dtlb_miss !== 1'b1) $display("FAIL wrap_evicted: got %b want 1", dc_dtlb_miss); else n_pass++;
      for (int k = 1; k < 5; k++) begin
         exp = {8'(8'h80 + k), 12'h123};
         drive_load({20'(20'h10 + k), 12'h123}, 1'b0); step();
         n_checks++; if (dc_paddr !== exp || dc_dtlb_miss !== 1'b0) $display("FAIL wrap_hit_%0d: got %h miss=%b want %h", k, dc_paddr, dc_dtlb_miss, exp); else n_pass++;
      end
      // rewrite 0x12 in place (rp stays at slot 1), then 0x15 must evict 0x11
      drive_tlbw(20'h00012, 8'hC2); step();
      drive_tlbw(20'h00015, 8'h85); step();
      drive_load({20'h00011, 12'h123}, 1'b0); step();
      n_checks++; if (dc_dtlb_miss !== 1'b1) $display("FAIL rewrite_evict11: got %b want 1", dc_dtlb_miss); else n_pass++;
      drive_load({20'h00012, 12'h123}, 1'b0); step();
      n_checks++; if (dc_paddr !== 20'hC2123) $display("FAIL rewrite_12: got %h want c2123", dc_paddr); else n_pass++;
      drive_load({20'h00015, 12'h123}, 1'b0); step();
      n_checks++; if (dc_paddr !== 20'h85123) $display("FAIL rewrite_15: got %h want 85123", dc_paddr); else n_pass++;
      drive_load({20'h00013, 12'h123}, 1'b0); step();
      n_checks++; if (dc_paddr !== 20'h83123) $display("FAIL rewrite_13: got %h want 83123", dc_paddr); else n_pass++;
   endtask

   task automatic test_stall();
      do_reset();
      drive_load(32'h0000_7000, 1'b1); tl_pc = 32'h100; step();
      n_checks++; if (dc_pc !== 32'h100) $display("FAIL stall_pre_pc: got %h want 100", dc_pc); else n_pass++;
      drive_tlbw(20'h00022, 8'h92); tl_pc = 32'h200; dc_stall = 1'b1;
      #1;
      n_checks++; if (tl_stall !== 1'b1) $display("FAIL tl_stall: got %b want 1", tl_stall); else n_pass++;
      step();
      for (int c = 0; c < 2; c++) begin
         drive_tlbw(20'h00021, 8'h91); tl_pc = 32'h200; dc_stall = 1'b1; step();
      end
      n_checks++; if (dc_pc !== 32'h100 || dc_flag_mem !== 1'b1 || dc_paddr !== 20'h07000) $display("FAIL stall_hold: got pc=%h mem=%b paddr=%h want 100/1/07000", dc_pc, dc_flag_mem, dc_paddr); else n_pass++;
      dc_stall = 1'b0; step();
      n_checks++; if (dc_pc !== 32'h200 || dc_flag_mem !== 1'b0) $display("FAIL stall_release: got pc=%h mem=%b want 200/0", dc_pc, dc_flag_mem); else n_pass++;
      drive_load(32'h0002_1010, 1'b0); step();
      n_checks++; if (dc_paddr !== 20'h91010) $display("FAIL stall_write_hit: got %h want 91010", dc_paddr); else n_pass++;
      drive_load(32'h0002_2000, 1'b0); step();
      n_checks++; if (dc_dtlb_miss !== 1'b1) $display("FAIL stall_no_write: got %b want 1", dc_dtlb_miss); else n_pass++;
   endtask

   task automatic test_kill_bypass();
      do_reset();
      drive_load(32'h0000_1000, 1'b1); tl_kill = 1'b1; step();
      n_checks++; if (dc_isvalid !== 1'b0) $display("FAIL kill_isvalid: got %b want 0", dc_isvalid); else n_pass++;
      drive_load(32'h0000_1000, 1'b1); tl_pc = 32'h300; step();
      drive_load(32'h0000_2000, 1'b1); tl_pc = 32'h400; tl_kill = 1'b1; dc_stall = 1'b1; step();
      n_checks++; if (dc_isvalid !== 1'b1 || dc_pc !== 32'h300) $display("FAIL kill_stall_hold: got v=%b pc=%h want 1/300", dc_isvalid, dc_pc); else n_pass++;
      dc_stall = 1'b0; step();
      n_checks++; if (dc_isvalid !== 1'b0 || dc_pc !== 32'h400) $display("FAIL kill_release: got v=%b pc=%h want 0/400", dc_isvalid, dc_pc); else n_pass++;
      drive_load(32'h1234_5678, 1'b1); step();
      n_checks++; if (dc_paddr !== 20'h45678 || dc_dtlb_miss !== 1'b0) $display("FAIL bypass: got %h miss=%b want 45678/0", dc_paddr, dc_dtlb_miss); else n_pass++;
      drive_tlbw(20'h00030, 8'h55); tl_kill = 1'b1; step();
      drive_tlbw(20'h00031, 8'h56); tl_supervisor = 1'b0; step();
      drive_tlbw(20'h00032, 8'h57); tl_flag_tlbwrite = TLBW_ITLB; step();
      for (int k = 0; k < 3; k++) begin
         drive_load({20'(20'h30 + k), 12'h000}, 1'b0); step();
         n_checks++; if (dc_dtlb_miss !== 1'b1) $display("FAIL ignored_write_%0d: got %b want 1", k, dc_dtlb_miss); else n_pass++;
      end
      set_idle(); tl_isvalid = 1'b1; tl_data = 32'h0003_0ABC; step();
      n_checks++; if (dc_paddr !== 20'h0 || dc_dtlb_miss !== 1'b0) $display("FAIL nonmem: got %h miss=%b want 0/0", dc_paddr, dc_dtlb_miss); else n_pass++;
   endtask

   task automatic test_mux();
      set_idle(); tl_isvalid = 1'b1; tl_flag_mul = 1'b1; tl_mul = 32'hDEAD_BEEF; tl_data = 32'h1;
      tl_thread = 2'd3; tl_dst = 5'd17; tl_isequal = 1'b1; tl_flag_branch = 1'b1; tl_itlb_miss = 1'b1;
      step();
      n_checks++; if (dc_data !== 32'hDEAD_BEEF) $display("FAIL mux_mul: got %h want deadbeef", dc_data); else n_pass++;
      n_checks++; if (dc_thread !== 2'd3 || dc_dst !== 5'd17 || dc_isequal !== 1'b1 || dc_flag_branch !== 1'b1 || dc_itlb_miss !== 1'b1)
         $display("FAIL passthru: got t=%h d=%h eq=%b br=%b im=%b want 3/11/1/1/1", dc_thread, dc_dst, dc_isequal, dc_flag_branch, dc_itlb_miss); else n_pass++;
      tl_flag_mul = 1'b0; step();
      n_checks++; if (dc_data !== 32'h1) $display("FAIL mux_alu: got %h want 00000001", dc_data); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      set_idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      test_reset();
      test_fill_hit();
      test_wrap();
      test_stall();
      test_kill_bypass();
      test_mux();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
